// File: rtl/scan_averager_if.sv
// Pixel-stream and averaged-output signals between the ADC stage, scan_averager and the FIFO.
// The slave modport is the averager's view; the master modport is the driver/FIFO side.
interface scan_averager_if #(
  parameter int PIX_W = 16
);
  logic [2:0]       avg_log2;
  logic             scan_start;
  logic             scan_abort;
  logic [PIX_W-1:0] pix_di;
  logic             pix_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_do;
  logic             out_valid;
  logic             busy;
  logic [3:0]       scan_idx;
  logic             overflow;
  logic             short_scan;

  modport master (
    output avg_log2, scan_start, scan_abort, pix_di, pix_valid, out_ready,
    input  out_do, out_valid, busy, scan_idx, overflow, short_scan
  );

  modport slave (
    input  avg_log2, scan_start, scan_abort, pix_di, pix_valid, out_ready,
    output out_do, out_valid, busy, scan_idx, overflow, short_scan
  );
endinterface

// File: rtl/scan_averager.sv
// Averages 2^K consecutive CCD scans pixel-by-pixel into one output scan.
// Define SCAN_AVG_ROUND_EN for round-half-up with saturation; default is floor.
module scan_averager #(
  parameter int PIX_W    = 16,
  parameter int NPIX     = 2048,
  parameter int MAX_LOG2 = 4,
  parameter int ACC_W    = PIX_W + MAX_LOG2
) (
  input logic            sys_clk_i,
  input logic            sys_rst_i,
  scan_averager_if.slave bus
);

  localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW = $clog2(NPIX + 1);
  localparam int SW = ACC_W + 1;
  localparam logic [CW-1:0] PCNT_MAX = CW'(NPIX);
  localparam logic [2:0]    K_MAX    = 3'(MAX_LOG2);

  typedef enum logic [1:0] {IDLE, FIRST, MID, LAST} state_e;

  logic [ACC_W-1:0] ram [NPIX];

  state_e           state_q, state_d, start_state;
  logic [CW-1:0]    pcnt_q, pcnt_d;
  logic [3:0]       idx_q, idx_d, idx_inc, last_idx;
  logic [2:0]       k_q, k_d, k_in;
  logic [ACC_W-1:0] rd_q, base, ram_wd;
  logic [PIX_W-1:0] out_do_q, out_do_d, result;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             short_q, short_d;
  logic             ram_we, pix_ok, pcnt_full;
  logic [SW-1:0]    sum;
`ifdef SCAN_AVG_ROUND_EN
  logic [SW-1:0]    rnd, avg;
`endif

  // With K=0 there is no stored partial sum, so the pixel passes straight through.
  always_comb begin
    base = (k_q == 3'd0) ? '0 : rd_q;
    sum  = SW'(base) + SW'(bus.pix_di);
`ifdef SCAN_AVG_ROUND_EN
    rnd    = (k_q == 3'd0) ? '0 : (SW'(1) << (k_q - 3'd1));
    avg    = (sum + rnd) >> k_q;
    result = (avg > SW'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : avg[PIX_W-1:0];
`else
    result = PIX_W'(sum >> k_q);
`endif
  end

  assign k_in        = (bus.avg_log2 > K_MAX) ? K_MAX : bus.avg_log2;
  assign start_state = (k_in == 3'd0) ? LAST : FIRST;
  assign pcnt_full   = (pcnt_q == PCNT_MAX);
  assign pix_ok      = bus.pix_valid && (pcnt_q < PCNT_MAX);
  assign idx_inc     = idx_q + 4'd1;
  assign last_idx    = 4'((5'd1 << k_q) - 5'd1);

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    idx_d       = idx_q;
    k_d         = k_q;
    out_do_d    = out_do_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q | (out_valid_q & ~bus.out_ready);
    short_d     = short_q;
    ram_we      = 1'b0;
    ram_wd      = ACC_W'(bus.pix_di);

    if (bus.scan_abort) begin
      state_d = IDLE;
      pcnt_d  = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      if (bus.scan_start) begin
        k_d     = k_in;
        idx_d   = '0;
        pcnt_d  = '0;
        state_d = start_state;
      end
    end else if (bus.scan_start && (pcnt_q != '0)) begin
      pcnt_d = '0;
      if (pcnt_full && (state_q != LAST)) begin
        idx_d   = idx_inc;
        state_d = (idx_inc == last_idx) ? LAST : MID;
      end else begin
        // A truncated scan poisons the running sum, so the sequence restarts.
        short_d = short_q | ~pcnt_full;
        k_d     = k_in;
        idx_d   = '0;
        state_d = start_state;
      end
    end else if (pix_ok) begin
      pcnt_d = pcnt_q + CW'(1);
      case (state_q)
        FIRST: ram_we = 1'b1;
        MID: begin
          ram_we = 1'b1;
          ram_wd = sum[ACC_W-1:0];
        end
        LAST: begin
          out_valid_d = 1'b1;
          out_do_d    = result;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      out_do_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      out_do_q    <= out_do_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      short_q     <= short_d;
    end
  end

  // Read address follows pcnt every cycle so the sum for the next pixel is ready before its strobe.
  always_ff @(posedge sys_clk_i) begin
    if (ram_we) ram[pcnt_q[AW-1:0]] <= ram_wd;
    rd_q <= ram[pcnt_q[AW-1:0]];
  end

  assign bus.out_do     = out_do_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.scan_idx   = idx_q;
  assign bus.overflow   = overflow_q;
  assign bus.short_scan = short_q;

endmodule

// File: tb/tb_scan_averager.sv
// Directed testbench for scan_averager with a reduced scan length of 16 pixels.
// Expected averages are hand-computed; SCAN_AVG_ROUND_EN selects the rounded values.
module tb_scan_averager;

  localparam int PIX_W = 16;
  localparam int NPIX  = 16;

`ifdef SCAN_AVG_ROUND_EN
  localparam logic [15:0] EXP_T2  = 16'd102;
  localparam logic [15:0] EXP_T4B = 16'd16;
`else
  localparam logic [15:0] EXP_T2  = 16'd101;
  localparam logic [15:0] EXP_T4B = 16'd15;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  int   out_count  = 0;
  int   cnt_before;
  logic got_v;
  logic [PIX_W-1:0] got_d;

  scan_averager_if #(.PIX_W(PIX_W)) bus ();

  scan_averager #(
    .PIX_W(PIX_W), .NPIX(NPIX), .MAX_LOG2(4)
  ) dut (
    .sys_clk_i(sys_clk),
    .sys_rst_i(sys_rst),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Counts every output strobe so that "no output" claims can be checked.
  always @(negedge sys_clk) if (sys_rst && bus.out_valid) out_count++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit abort, input bit pv,
                               input logic [15:0] pix, input bit ready);
    bus.scan_start = start;
    bus.scan_abort = abort;
    bus.pix_valid  = pv;
    bus.pix_di     = pix;
    bus.out_ready  = ready;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sendPixel(input logic [15:0] pix, input bit ready);
    applyStimulus(1'b0, 1'b0, 1'b1, pix, ready);
    got_v = bus.out_valid;
    got_d = bus.out_do;
    applyStimulus(1'b0, 1'b0, 1'b0, pix, ready);
  endtask

  task automatic startScan();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic abortScan();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic runScan(input logic [15:0] base, input logic [15:0] step, input bit expect_out,
                         input logic [15:0] exp_base, input logic [15:0] exp_step,
                         input int ready_low_idx, input string tag);
    logic [15:0] v, e;
    for (int n = 0; n < NPIX; n++) begin
      v = base + step * 16'(n);
      e = exp_base + exp_step * 16'(n);
      sendPixel(v, n != ready_low_idx);
      checkOutput($sformatf("%s_valid%0d", tag, n), 32'(got_v), 32'(expect_out));
      if (expect_out) checkOutput($sformatf("%s_data%0d", tag, n), 32'(got_d), 32'(e));
    end
  endtask

  initial begin
    bus.avg_log2   = 3'd0;
    bus.scan_start = 1'b0;
    bus.scan_abort = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_di     = '0;
    bus.out_ready  = 1'b1;
    #12;
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_idx", 32'(bus.scan_idx), 0);
    checkOutput("rst_do", 32'(bus.out_do), 0);
    checkOutput("rst_ovf", 32'(bus.overflow), 0);
    checkOutput("rst_short", 32'(bus.short_scan), 0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    $display("[TB] test 1: K=0 pass-through");
    bus.avg_log2 = 3'd0;
    startScan();
    checkOutput("t1_busy", 32'(bus.busy), 1);
    runScan(16'd0, 16'd1, 1'b1, 16'd0, 16'd1, -1, "t1");
    checkOutput("t1_count", 32'(out_count), NPIX);
    sendPixel(16'd7, 1'b1);
    checkOutput("t1_extra_pixel", 32'(got_v), 0);
    abortScan();
    checkOutput("t1_abort_busy", 32'(bus.busy), 0);

    $display("[TB] test 2: K=2 four constant scans");
    bus.avg_log2 = 3'd2;
    startScan();
    for (int s = 0; s < 4; s++) begin
      if (s > 0) startScan();
      checkOutput($sformatf("t2_idx%0d", s), 32'(bus.scan_idx), 32'(s));
      runScan(16'(100 + s), 16'd0, s == 3, EXP_T2, 16'd0, -1, "t2");
    end
    checkOutput("t2_count", 32'(out_count), 2 * NPIX);
    startScan();
    checkOutput("t2_wrap_idx", 32'(bus.scan_idx), 0);
    checkOutput("t2_wrap_busy", 32'(bus.busy), 1);
    abortScan();

    $display("[TB] test 3: K clamped to 4, full-scale pixels");
    bus.avg_log2 = 3'd7;
    startScan();
    for (int s = 0; s < 16; s++) begin
      if (s > 0) startScan();
      checkOutput($sformatf("t3_idx%0d", s), 32'(bus.scan_idx), 32'(s));
      runScan(16'hFFFF, 16'd0, s == 15, 16'hFFFF, 16'd0, -1, "t3");
    end
    abortScan();

    $display("[TB] test 4: K=1 short scan then full pair");
    bus.avg_log2 = 3'd1;
    startScan();
    startScan();
    checkOutput("t4_empty_idx", 32'(bus.scan_idx), 0);
    checkOutput("t4_empty_short", 32'(bus.short_scan), 0);
    for (int n = 0; n < 10; n++) sendPixel(16'd500, 1'b1);
    startScan();
    checkOutput("t4_short", 32'(bus.short_scan), 1);
    checkOutput("t4_idx_restart", 32'(bus.scan_idx), 0);
    runScan(16'd10, 16'd3, 1'b0, 16'd0, 16'd0, -1, "t4a");
    startScan();
    checkOutput("t4_idx1", 32'(bus.scan_idx), 1);
    runScan(16'd21, 16'd1, 1'b1, EXP_T4B, 16'd2, -1, "t4b");
    abortScan();

    $display("[TB] test 5: K=2 abort during scan 2");
    bus.avg_log2 = 3'd2;
    startScan();
    runScan(16'd1, 16'd1, 1'b0, 16'd0, 16'd0, -1, "t5s0");
    startScan();
    runScan(16'd2, 16'd1, 1'b0, 16'd0, 16'd0, -1, "t5s1");
    startScan();
    checkOutput("t5_idx2", 32'(bus.scan_idx), 2);
    for (int n = 0; n < 5; n++) sendPixel(16'd9, 1'b1);
    cnt_before = out_count;
    abortScan();
    checkOutput("t5_busy", 32'(bus.busy), 0);
    checkOutput("t5_idx", 32'(bus.scan_idx), 0);
    sendPixel(16'd9, 1'b1);
    checkOutput("t5_no_output", 32'(out_count), 32'(cnt_before));
    startScan();
    for (int n = 0; n < 3; n++) sendPixel(16'd9, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    checkOutput("t5_start_abort_busy", 32'(bus.busy), 0);

    $display("[TB] test 6: out_ready low gives sticky overflow");
    bus.avg_log2 = 3'd0;
    checkOutput("t6_ovf_before", 32'(bus.overflow), 0);
    startScan();
    runScan(16'd200, 16'd1, 1'b1, 16'd200, 16'd1, 5, "t6");
    checkOutput("t6_ovf", 32'(bus.overflow), 1);
    abortScan();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    checkOutput("t6_ovf_sticky", 32'(bus.overflow), 1);
    checkOutput("t6_short_sticky", 32'(bus.short_scan), 1);
    startScan();
    sys_rst = 1'b0;
    #2;
    checkOutput("t6_rst_ovf", 32'(bus.overflow), 0);
    checkOutput("t6_rst_short", 32'(bus.short_scan), 0);
    checkOutput("t6_rst_busy", 32'(bus.busy), 0);
    checkOutput("t6_rst_idx", 32'(bus.scan_idx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
